// File: rtl/calc_sequencer.sv
// Operation sequencer for the 9-bit calculator: button conditioning, screen/op state,
// add/sub/shift-add multiply on latched operands, and req/ack update signalling to the LCD.
module calc_sequencer #(
    parameter int DEB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  numberA,
    input  logic [8:0]  numberB,
    input  logic        B0,
    input  logic        B1,
    input  logic        B2,
    input  logic        B3,
    output logic        screen,
    output logic [1:0]  op,
    output logic [17:0] result,
    output logic        negative,
    output logic        result_valid,
    output logic        busy,
    output logic        upd_req,
    input  logic        upd_ack
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [1:0] {S_OFF, S_IDLE, S_CALC, S_SHOW} state_t;
    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_MULTI = 2'd1,
        OP_SUB   = 2'd2,
        OP_SOMA  = 2'd3
    } op_t;

    // ---------------- button conditioning (bit i = Bi) ----------------
    logic [3:0]    btn_raw;
    logic [3:0]    sync1, sync2, deb, press;
    logic [CW-1:0] cnt [4];

    assign btn_raw = {B3, B2, B1, B0};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            // NOTE: the counter array is small and must restart from zero, so it is reset like any register.
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        deb[i]   <= sync2[i];
                        cnt[i]   <= '0;
                        press[i] <= sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // ---------------- control FSM ----------------
    state_t      state_q, state_d;
    op_t         op_q, new_op;
    logic        go_off, go_idle, start, finish;
    logic [8:0]  a_q, b_q;
    logic [3:0]  idx_q;
    logic        calc_last;

    assign calc_last = (op_q != OP_MULTI) || (idx_q == 4'd8);

    // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        go_off  = 1'b0;
        go_idle = 1'b0;
        start   = 1'b0;
        finish  = 1'b0;
        new_op  = OP_START;
        case (state_q)
            S_OFF: begin
                if (press[0]) begin
                    state_d = S_IDLE;
                    go_idle = 1'b1;
                end
            end
            S_IDLE, S_SHOW: begin
                if (press[0]) begin
                    state_d = S_OFF;
                    go_off  = 1'b1;
                end else if (press[1]) begin
                    start  = 1'b1;
                    new_op = OP_MULTI;
                end else if (press[2]) begin
                    start  = 1'b1;
                    new_op = OP_SUB;
                end else if (press[3]) begin
                    start  = 1'b1;
                    new_op = OP_SOMA;
                end
                if (start) state_d = S_CALC;
            end
            S_CALC: begin
                if (press[0]) begin
                    state_d = S_OFF;
                    go_off  = 1'b1;
                end else if (calc_last) begin
                    state_d = S_SHOW;
                    finish  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [17:0] a_ext, b_ext, mul_term;
    logic [8:0]  diff_ab;
    logic        a_ge_b;

    assign a_ext    = {9'd0, a_q};
    assign b_ext    = {9'd0, b_q};
    assign mul_term = b_q[idx_q] ? (a_ext << idx_q) : 18'd0;
    assign a_ge_b   = (a_q >= b_q);
    assign diff_ab  = a_ge_b ? (a_q - b_q) : (b_q - a_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            screen       <= 1'b1;
            op_q         <= OP_START;
            result       <= '0;
            negative     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
        end else begin
            state_q <= state_d;
            if (go_off) begin
                screen       <= 1'b0;
                op_q         <= OP_START;
                result_valid <= 1'b0;
                busy         <= 1'b0;
            end
            if (go_idle) begin
                screen <= 1'b1;
                op_q   <= OP_START;
            end
            if (start) begin
                a_q          <= numberA;
                b_q          <= numberB;
                op_q         <= new_op;
                result_valid <= 1'b0;
                busy         <= 1'b1;
                result       <= '0;
                negative     <= 1'b0;
                idx_q        <= '0;
            end
            // Multiply reuses result as its accumulator; it is hidden behind busy until finish.
            if (state_q == S_CALC && !go_off) begin
                case (op_q)
                    OP_SOMA: begin
                        result   <= a_ext + b_ext;
                        negative <= 1'b0;
                    end
                    OP_SUB: begin
                        result   <= {9'd0, diff_ab};
                        negative <= !a_ge_b;
                    end
                    OP_MULTI: begin
                        result <= result + mul_term;
                        idx_q  <= idx_q + 4'd1;
                    end
                    default: ;
                endcase
                if (finish) begin
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                end
            end
        end
    end

    assign op = op_q;

    // ---------------- LCD update handshake ----------------
    logic       screen_p, rv_p;
    op_t        op_p;
    logic       disp_change;

    assign disp_change = (screen != screen_p) || (op_q != op_p) || (result_valid != rv_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            screen_p <= 1'b1;
            op_p     <= OP_START;
            rv_p     <= 1'b0;
            upd_req  <= 1'b0;
        end else begin
            screen_p <= screen;
            op_p     <= op_q;
            rv_p     <= result_valid;
            // A change arriving with the ack re-arms the request, so nothing is lost.
            upd_req  <= disp_change || (upd_req && !upd_ack);
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer (DEB_CYCLES = 4): a raw press is seen
// as a state change 7 edges after it is raised, and outputs are sampled 1 ns after each edge.
module tb_calc_sequencer;

    logic        clk;
    logic        rst;
    logic [8:0]  numberA, numberB;
    logic        B0, B1, B2, B3;
    logic        screen;
    logic [1:0]  op;
    logic [17:0] result;
    logic        negative, result_valid, busy, upd_req;
    logic        upd_ack;

    int n_asserts = 0;
    int n_fail    = 0;

    calc_sequencer #(.DEB_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .numberA      (numberA),
        .numberB      (numberB),
        .B0           (B0),
        .B1           (B1),
        .B2           (B2),
        .B3           (B3),
        .screen       (screen),
        .op           (op),
        .result       (result),
        .negative     (negative),
        .result_valid (result_valid),
        .busy         (busy),
        .upd_req      (upd_req),
        .upd_ack      (upd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        numberA = '0; numberB = '0;
        B0 = 0; B1 = 0; B2 = 0; B3 = 0;
        upd_ack = 0;
        #2;
        check("rst_screen", screen, 1);
        check("rst_op", op, 0);
        check("rst_result", result, 0);
        check("rst_negative", negative, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_upd_req", upd_req, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick(3);
        check("idle_no_req", upd_req, 0);

        // ---- add: 300 + 250 ----
        numberA = 9'd300; numberB = 9'd250; B3 = 1;
        tick(6);
        check("add_op_before", op, 0);
        tick(1);
        check("add_op", op, 3);
        check("add_busy", busy, 1);
        check("add_valid_low", result_valid, 0);
        check("add_req_not_yet", upd_req, 0);
        tick(1);
        check("add_valid", result_valid, 1);
        check("add_busy_low", busy, 0);
        check("add_result", result, 550);
        check("add_neg", negative, 0);
        check("add_req", upd_req, 1);
        B3 = 0;
        tick(8);
        check("add_req_held", upd_req, 1);
        upd_ack = 1;
        tick(1);
        upd_ack = 0;
        check("add_req_acked", upd_req, 0);
        tick(2);
        check("add_req_stays_low", upd_req, 0);

        // ---- sub, negative: 5 - 9 ----
        numberA = 9'd5; numberB = 9'd9; B2 = 1;
        tick(7);
        check("sub1_op", op, 2);
        check("sub1_busy", busy, 1);
        tick(1);
        check("sub1_valid", result_valid, 1);
        check("sub1_result", result, 4);
        check("sub1_neg", negative, 1);
        B2 = 0;
        tick(8);

        // ---- sub, positive: 9 - 5, issued from SHOW ----
        numberA = 9'd9; numberB = 9'd5; B2 = 1;
        tick(7);
        check("sub2_valid_low", result_valid, 0);
        check("sub2_busy", busy, 1);
        tick(1);
        check("sub2_valid", result_valid, 1);
        check("sub2_result", result, 4);
        check("sub2_neg", negative, 0);
        B2 = 0;
        tick(8);

        // ---- bounce shorter than the debounce window ----
        for (int k = 0; k < 5; k++) begin
            B3 = 1; tick(2);
            B3 = 0; tick(2);
        end
        tick(8);
        check("bounce_op", op, 2);
        check("bounce_valid", result_valid, 1);
        check("bounce_busy", busy, 0);

        // ---- B1 and B3 together, then multiply 511*511 with A changed mid-run ----
        numberA = 9'd511; numberB = 9'd511; B1 = 1; B3 = 1;
        tick(7);
        check("prio_op", op, 1);
        check("mul_busy_start", busy, 1);
        numberA = 9'd3; B1 = 0; B3 = 0;
        tick(8);
        check("mul_busy_end", busy, 1);
        check("mul_valid_low", result_valid, 0);
        tick(1);
        check("mul_valid", result_valid, 1);
        check("mul_busy_low", busy, 0);
        check("mul_result", result, 261121);
        check("mul_neg", negative, 0);
        tick(8);
        check("prio_no_queued", op, 1);
        check("mul_result_stable", result, 261121);

        // ---- B0 mid-multiply aborts to OFF ----
        numberA = 9'd7; numberB = 9'd3; B1 = 1;
        tick(7);
        check("abort_mul_busy", busy, 1);
        B1 = 0; B0 = 1;
        tick(6);
        check("abort_before_screen", screen, 1);
        check("abort_before_busy", busy, 1);
        tick(1);
        check("off_screen", screen, 0);
        check("off_op", op, 0);
        check("off_valid", result_valid, 0);
        check("off_busy", busy, 0);
        tick(5);
        check("off_valid_discard", result_valid, 0);
        B0 = 0;
        tick(8);

        // ---- B3 in OFF is ignored ----
        numberA = 9'd1; numberB = 9'd1; B3 = 1;
        tick(7);
        check("off_b3_op", op, 0);
        check("off_b3_busy", busy, 0);
        check("off_b3_screen", screen, 0);
        B3 = 0;
        tick(8);

        // ---- B0 again: back to IDLE ----
        B0 = 1;
        tick(7);
        check("on_screen", screen, 1);
        check("on_op", op, 0);
        check("on_valid", result_valid, 0);
        B0 = 0;
        tick(8);

        // ---- async reset mid-CALC ----
        numberA = 9'd511; numberB = 9'd2; B1 = 1;
        tick(7);
        check("rstcalc_busy", busy, 1);
        tick(2);
        B1 = 0;
        rst = 1'b1;
        #2;
        check("rstcalc_busy_low", busy, 0);
        check("rstcalc_op", op, 0);
        check("rstcalc_screen", screen, 1);
        check("rstcalc_valid", result_valid, 0);
        check("rstcalc_result", result, 0);
        check("rstcalc_upd_req", upd_req, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(8);

        // ---- coalesced handshake: add then screen off, one request, one ack ----
        numberA = 9'd2; numberB = 9'd3; B3 = 1;
        tick(7);
        check("hs_op", op, 3);
        check("hs_req_not_yet", upd_req, 0);
        tick(1);
        check("hs_result", result, 5);
        check("hs_req", upd_req, 1);
        B3 = 0;
        tick(8);
        check("hs_req_held", upd_req, 1);
        B0 = 1;
        tick(7);
        check("hs_off_screen", screen, 0);
        check("hs_req_still", upd_req, 1);
        tick(2);
        upd_ack = 1;
        tick(1);
        upd_ack = 0;
        check("hs_req_acked", upd_req, 0);
        tick(3);
        check("hs_req_low", upd_req, 0);
        B0 = 0;
        tick(8);
        upd_ack = 1;
        tick(2);
        upd_ack = 0;
        check("hs_stray_ack", upd_req, 0);
        B0 = 1;
        tick(7);
        check("hs_on_screen", screen, 1);
        check("hs_on_req_not_yet", upd_req, 0);
        tick(1);
        check("hs_on_req", upd_req, 1);
        B0 = 0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
